// File: rtl/cv32e40s_pkg.sv
// Shared types for the RV32M divide sequencer: opcodes, FSM states and the
// latched per-operation control word.
package cv32e40s_pkg;

  localparam int unsigned DIV_W = 32;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {
    DIV_DIV  = 2'b00,
    DIV_DIVU = 2'b01,
    DIV_REM  = 2'b10,
    DIV_REMU = 2'b11
  } div_opcode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    INIT   = 2'b01,
    DIVIDE = 2'b10,
    FINISH = 2'b11
  } div_state_e;

  typedef struct packed {
    div_opcode_e opcode;
    logic        sign_a;
    logic        sign_b;
  } div_ctrl_t;

endpackage

// File: rtl/cv32e40s_div_seq.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer: normalises the divisor using the
// ALU's CLZ unit and shifter, then runs a restoring shift-subtract loop.
module cv32e40s_div_seq
  import cv32e40s_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  output logic                ready_o,
  input  div_opcode_e         operator_i,
  input  logic [DIV_W-1:0]    op_a_i,
  input  logic [DIV_W-1:0]    op_b_i,
  input  logic                kill_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [DIV_W-1:0]    result_o,
  output logic [DIV_W-1:0]    alu_op_b_o,
  output logic                div_clz_en_o,
  output logic [DIV_W-1:0]    div_clz_data_rev_o,
  input  logic [CNT_W-1:0]    div_clz_result_i,
  output logic                div_shift_en_o,
  output logic [CNT_W-1:0]    div_shift_amt_o,
  input  logic [DIV_W-1:0]    div_op_b_shifted_i
);

  function automatic logic [DIV_W-1:0] negate(input logic [DIV_W-1:0] v);
    return DIV_W'(~v + DIV_W'(1));
  endfunction

  function automatic logic [DIV_W-1:0] abs_val(input logic [DIV_W-1:0] v, input logic neg);
    return neg ? negate(v) : v;
  endfunction

  function automatic logic [DIV_W-1:0] bit_rev(input logic [DIV_W-1:0] v);
    logic [DIV_W-1:0] r;
    for (int i = 0; i < int'(DIV_W); i++) r[i] = v[DIV_W-1-i];
    return r;
  endfunction

  function automatic logic is_signed_op(input div_opcode_e op);
    return (op == DIV_DIV) || (op == DIV_REM);
  endfunction

  function automatic logic is_div_op(input div_opcode_e op);
    return (op == DIV_DIV) || (op == DIV_DIVU);
  endfunction

  // Sign correction applied once, as the result is registered for FINISH
  function automatic logic [DIV_W-1:0] fixup(input div_ctrl_t c, input logic [DIV_W-1:0] q,
                                             input logic [DIV_W-1:0] r);
    logic [DIV_W-1:0] res;
    unique case (c.opcode)
      DIV_DIV:  res = (c.sign_a ^ c.sign_b) ? negate(q) : q;
      DIV_DIVU: res = q;
      DIV_REM:  res = c.sign_a ? negate(r) : r;
      default:  res = r;
    endcase
    return res;
  endfunction

  div_state_e         state_q, state_n;
  div_ctrl_t          ctrl_q, ctrl_n;
  logic [DIV_W-1:0]   a_abs_q, a_abs_n;
  logic [DIV_W-1:0]   b_abs_q, b_abs_n;
  logic [DIV_W-1:0]   rem_q, rem_n;
  logic [DIV_W-1:0]   quot_q, quot_n;
  logic [DIV_W-1:0]   divisor_q, divisor_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [DIV_W-1:0]   result_n;
  logic               ready_n, valid_n, claim_n;
  logic               shift_en_q;

  logic [DIV_W:0]     diff;
  logic               q_bit;
  logic [DIV_W-1:0]   rem_iter;
  logic [DIV_W-1:0]   quot_iter;
  logic               sign_a_in, sign_b_in;

  // One restoring step: a borrow out of the 33-bit subtract means rem < divisor
  assign diff      = {1'b0, rem_q} - {1'b0, divisor_q};
  assign q_bit     = ~diff[DIV_W];
  assign rem_iter  = q_bit ? diff[DIV_W-1:0] : rem_q;
  assign quot_iter = {quot_q[DIV_W-2:0], q_bit};

  assign sign_a_in = is_signed_op(operator_i) & op_a_i[DIV_W-1];
  assign sign_b_in = is_signed_op(operator_i) & op_b_i[DIV_W-1];

  always_comb begin
    state_n   = state_q;
    ctrl_n    = ctrl_q;
    a_abs_n   = a_abs_q;
    b_abs_n   = b_abs_q;
    rem_n     = rem_q;
    quot_n    = quot_q;
    divisor_n = divisor_q;
    cnt_n     = cnt_q;
    result_n  = result_o;

    unique case (state_q)
      IDLE: begin
        if (valid_i && !kill_i) begin
          ctrl_n  = '{opcode: operator_i, sign_a: sign_a_in, sign_b: sign_b_in};
          a_abs_n = abs_val(op_a_i, sign_a_in);
          b_abs_n = abs_val(op_b_i, sign_b_in);
          if (op_b_i == '0) begin
            state_n  = FINISH;
            result_n = is_div_op(operator_i) ? '1 : op_a_i;
          end else begin
            state_n = INIT;
          end
        end
      end
      INIT: begin
        cnt_n     = div_clz_result_i;
        divisor_n = div_op_b_shifted_i;
        rem_n     = a_abs_q;
        quot_n    = '0;
        state_n   = DIVIDE;
      end
      DIVIDE: begin
        rem_n     = rem_iter;
        quot_n    = quot_iter;
        divisor_n = divisor_q >> 1;
        if (cnt_q == '0) begin
          state_n  = FINISH;
          result_n = fixup(ctrl_q, quot_iter, rem_iter);
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      FINISH: begin
        if (ready_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (kill_i) begin
      state_n  = IDLE;
      result_n = '0;
    end

    ready_n = (state_n == IDLE);
    valid_n = (state_n == FINISH);
    claim_n = (state_n == INIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ctrl_q       <= '0;
      a_abs_q      <= '0;
      b_abs_q      <= '0;
      rem_q        <= '0;
      quot_q       <= '0;
      divisor_q    <= '0;
      cnt_q        <= '0;
      result_o     <= '0;
      ready_o      <= 1'b1;
      valid_o      <= 1'b0;
      div_clz_en_o <= 1'b0;
      shift_en_q   <= 1'b0;
    end else begin
      state_q      <= state_n;
      ctrl_q       <= ctrl_n;
      a_abs_q      <= a_abs_n;
      b_abs_q      <= b_abs_n;
      rem_q        <= rem_n;
      quot_q       <= quot_n;
      divisor_q    <= divisor_n;
      cnt_q        <= cnt_n;
      result_o     <= result_n;
      ready_o      <= ready_n;
      valid_o      <= valid_n;
      div_clz_en_o <= claim_n;
      shift_en_q   <= claim_n;
    end
  end

  // ALU CLZ/shifter sees divisor data only while the sequencer owns it
  assign div_shift_en_o     = shift_en_q;
  assign alu_op_b_o         = b_abs_q;
  assign div_clz_data_rev_o = (state_q == INIT) ? bit_rev(b_abs_q) : '0;
  assign div_shift_amt_o    = (state_q == INIT) ? div_clz_result_i : '0;

endmodule
